// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding and LFSR constants for the BIST controller
package bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, COMPARE, DONE} bist_state_e;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED  = 16'hACE1;
endpackage

// File: rtl/bist_lfsr16.sv
// bist_lfsr16: 16-bit Fibonacci shift register; data=0 gives a pattern generator, data=responses gives a MISR
module bist_lfsr16 import bist_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic [15:0] data,
  output logic [15:0] q
);
  always_ff @(posedge clk)
    if (rst || load) q <= seed;
    else if (en) q <= {q[14:0], ^(q & LFSR_TAPS)} ^ data;
endmodule

// File: rtl/bist_ctrl.sv
// bist_ctrl: BIST controller (LFSR patterns in, MISR compaction out); BIST_RESTART_EN allows restart from DONE
module bist_ctrl import bist_pkg::*; #(
  parameter int          N_PATTERNS = 1024,
  parameter int          CUT_LAT    = 1,
  parameter logic [15:0] LFSR_SEED  = DEF_SEED,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input  logic CLK,
  input  logic RST,
  input  logic bist_start,
  input  logic in_k,
  input  logic in_j,
  input  logic in_en,
  output logic cut_k,
  output logic cut_j,
  output logic cut_en,
  input  logic cut_synced_d,
  input  logic cut_sync_err_d,
  output logic bist_active,
  output logic pass_fail,
  output logic bist_end
);
`ifdef BIST_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif
  localparam logic [16:0] LAST  = 17'(N_PATTERNS + CUT_LAT - 1);
  localparam logic [16:0] N_LIM = 17'(N_PATTERNS);
  localparam logic [16:0] LAT   = 17'(CUT_LAT);
  bist_state_e state, nxt;
  logic [16:0] cnt;
  logic [15:0] lfsr, misr;
  logic start_ok, run;
  assign run         = state == RUN;
  assign start_ok    = bist_start && (state == IDLE || (RESTART && state == DONE));
  assign bist_active = run || state == COMPARE;
  assign bist_end    = state == DONE;
  assign {cut_k, cut_j, cut_en} = bist_active ? lfsr[2:0] : {in_k, in_j, in_en};
  always_ff @(posedge CLK) state <= RST ? IDLE : nxt;
  always_comb begin
    nxt = state;
    nxt = start_ok ? RUN :
          (run && cnt == LAST) ? COMPARE :
          state == COMPARE ? DONE : state;
  end
  always_ff @(posedge CLK)
    if (RST || start_ok) cnt <= '0;
    else if (run) cnt <= cnt + 17'd1;
  always_ff @(posedge CLK)
    if (RST || start_ok) pass_fail <= 1'b0;
    else if (state == COMPARE) pass_fail <= misr == GOLDEN_SIG;
  bist_lfsr16 u_lfsr (
    .clk(CLK), .rst(RST), .en(run && cnt < N_LIM), .load(start_ok),
    .seed(LFSR_SEED), .data(16'h0000), .q(lfsr)
  );
  // responses lag patterns by CUT_LAT, so compaction starts CUT_LAT cycles into RUN
  bist_lfsr16 u_misr (
    .clk(CLK), .rst(RST), .en(run && cnt + 17'd1 > LAT), .load(start_ok),
    .seed(16'h0000), .data({14'b0, cut_sync_err_d, cut_synced_d}), .q(misr)
  );
endmodule
